// File: rtl/spu_issue_ctrl.sv
// Special-purpose-unit issue scheduler: in-order queue that releases ops at ROB head and stalls behind serializing ops.
// Optional same-cycle head bypass for an empty queue is enabled by defining SPU_HEAD_BYPASS_EN.
module spu_issue_ctrl #(
  parameter int QDEPTH    = 4,
  parameter int ROB_W     = 4,
  parameter int PAYLOAD_W = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  input  logic [ROB_W-1:0]     enq_rob_entry,
  input  logic                 enq_is_serial,
  input  logic [PAYLOAD_W-1:0] enq_payload,
  input  logic [ROB_W-1:0]     rob_head,
  input  logic                 commit_valid,
  input  logic [ROB_W-1:0]     commit_rob_entry,
  output logic                 issue_valid,
  output logic [ROB_W-1:0]     issue_rob_entry,
  output logic [PAYLOAD_W-1:0] issue_payload,
  output logic                 serial_busy
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

  typedef enum logic [0:0] {
    S_IDLE        = 1'b0,
    S_WAIT_COMMIT = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [ROB_W-1:0]     wait_tag_r;
  logic [ROB_W-1:0]     wait_tag_nxt_s;
  logic [ROB_W-1:0]     rob_q_r     [QDEPTH];
  logic [PAYLOAD_W-1:0] payload_q_r [QDEPTH];
  logic [QDEPTH-1:0]    serial_q_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [CNT_W-1:0]     count_r;

  logic                 empty_s;
  logic                 head_match_s;
  logic                 bypass_s;
  logic                 issue_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 sel_serial_s;
  logic [ROB_W-1:0]     sel_rob_s;
  logic [PAYLOAD_W-1:0] sel_payload_s;

  assign empty_s      = (count_r == {CNT_W{1'b0}});
  assign head_match_s = !empty_s && (rob_q_r[rd_ptr_r] == rob_head);
  assign enq_ready    = !reset && (count_r != FULL_CNT);

`ifdef SPU_HEAD_BYPASS_EN
  assign bypass_s = empty_s && enq_valid && (enq_rob_entry == rob_head);
`else
  assign bypass_s = 1'b0;
`endif

  assign issue_s = !reset && !flush && (state_r == S_IDLE) && (head_match_s || bypass_s);
  // A bypassed op goes straight to the SPU and never occupies a queue slot.
  assign push_s  = enq_valid && enq_ready && !flush && !(issue_s && bypass_s);
  assign pop_s   = issue_s && !bypass_s;

  // Select the issuing op: incoming bundle on bypass, otherwise the queue head.
  always_comb begin
    sel_rob_s     = rob_q_r[rd_ptr_r];
    sel_payload_s = payload_q_r[rd_ptr_r];
    sel_serial_s  = serial_q_r[rd_ptr_r];
    if (bypass_s) begin
      sel_rob_s     = enq_rob_entry;
      sel_payload_s = enq_payload;
      sel_serial_s  = enq_is_serial;
    end else begin
      sel_rob_s     = rob_q_r[rd_ptr_r];
      sel_payload_s = payload_q_r[rd_ptr_r];
      sel_serial_s  = serial_q_r[rd_ptr_r];
    end
  end

  assign issue_valid     = issue_s;
  assign issue_rob_entry = issue_s ? sel_rob_s : {ROB_W{1'b0}};
  assign issue_payload   = issue_s ? sel_payload_s : {PAYLOAD_W{1'b0}};
  assign serial_busy     = !reset && (state_r == S_WAIT_COMMIT);

  // Next-state logic: serializing issue waits for its own commit.
  always_comb begin
    state_nxt_s    = state_r;
    wait_tag_nxt_s = wait_tag_r;
    if (reset || flush) begin
      state_nxt_s    = S_IDLE;
      wait_tag_nxt_s = {ROB_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (issue_s && sel_serial_s) begin
            state_nxt_s    = S_WAIT_COMMIT;
            wait_tag_nxt_s = sel_rob_s;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_WAIT_COMMIT: begin
          if (commit_valid && (commit_rob_entry == wait_tag_r)) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_WAIT_COMMIT;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // FSM state and wait tag registers.
  always_ff @(posedge clk) begin
    state_r    <= state_nxt_s;
    wait_tag_r <= wait_tag_nxt_s;
  end

  // Queue pointers and occupancy; flush and reset empty the queue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      rob_q_r[wr_ptr_r]     <= enq_rob_entry;
      payload_q_r[wr_ptr_r] <= enq_payload;
      serial_q_r[wr_ptr_r]  <= enq_is_serial;
    end
  end

endmodule

// File: tb/tb_spu_issue_ctrl.sv
// Self-checking bench for spu_issue_ctrl: scoreboard of expected issues plus cycle-level timing checks.
module tb_spu_issue_ctrl;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         enq_valid;
  logic         enq_ready;
  logic [3:0]   enq_rob_entry;
  logic         enq_is_serial;
  logic [127:0] enq_payload;
  logic [3:0]   rob_head;
  logic         commit_valid;
  logic [3:0]   commit_rob_entry;
  logic         issue_valid;
  logic [3:0]   issue_rob_entry;
  logic [127:0] issue_payload;
  logic         serial_busy;

  int tests_run = 0;
  int tests_failed = 0;
  logic [3:0] exp_q[$];
  logic obs_iv, obs_sb, obs_er;

`ifdef SPU_HEAD_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  spu_issue_ctrl #(.QDEPTH(4), .ROB_W(4), .PAYLOAD_W(128)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_rob_entry(enq_rob_entry),
    .enq_is_serial(enq_is_serial), .enq_payload(enq_payload),
    .rob_head(rob_head), .commit_valid(commit_valid), .commit_rob_entry(commit_rob_entry),
    .issue_valid(issue_valid), .issue_rob_entry(issue_rob_entry),
    .issue_payload(issue_payload), .serial_busy(serial_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pay(input logic [3:0] r);
    return {32{r}} ^ {4{32'h9E37_79B9}};
  endfunction

  task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, score any issue, return just after posedge.
  task automatic step();
    logic [3:0] e;
    @(negedge clk);
    obs_iv = issue_valid;
    obs_sb = serial_busy;
    obs_er = enq_ready;
    if (issue_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", {128'd0, issue_rob_entry}, 132'h1_0000);
      end else begin
        e = exp_q.pop_front();
        check("issue_rob", {128'd0, issue_rob_entry}, {128'd0, e});
        check("issue_payload", {4'd0, issue_payload}, {4'd0, pay(e)});
      end
    end else begin
      check("idle_outputs_zero", {issue_rob_entry, issue_payload}, 132'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic [3:0] r, input logic s);
    enq_valid     = 1'b1;
    enq_rob_entry = r;
    enq_is_serial = s;
    enq_payload   = pay(r);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_rob_entry = 4'd0;
    enq_is_serial = 1'b0; enq_payload = 128'd0; rob_head = 4'd0;
    commit_valid = 1'b0; commit_rob_entry = 4'd0;

    // Reset held two cycles.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_issue_valid", {131'd0, obs_iv}, 132'd0);
      check("rst_serial_busy", {131'd0, obs_sb}, 132'd0);
      check("rst_enq_ready", {131'd0, obs_er}, 132'd0);
    end
    reset = 1'b0;
    step();
    check("post_rst_enq_ready", {131'd0, obs_er}, 132'd1);

    // Non-serial op waits for ROB head.
    rob_head = 4'd3;
    drive_enq(4'd5, 1'b0); exp_q.push_back(4'd5);
    step();
    check("t2_no_issue_enq", {131'd0, obs_iv}, 132'd0);
    enq_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_no_issue_wait", {131'd0, obs_iv}, 132'd0);
    end
    rob_head = 4'd5;
    step();
    check("t2_issue_at_head", {131'd0, obs_iv}, 132'd1);
    check("t2_no_serial", {131'd0, obs_sb}, 132'd0);
    step();
    check("t2_serial_after", {131'd0, obs_sb}, 132'd0);

    // Serializing op blocks the next op until it commits.
    rob_head = 4'd6;
    drive_enq(4'd7, 1'b1); exp_q.push_back(4'd7);
    step();
    drive_enq(4'd8, 1'b0); exp_q.push_back(4'd8);
    step();
    check("t3_no_issue_before_head", {131'd0, obs_iv}, 132'd0);
    enq_valid = 1'b0; rob_head = 4'd7;
    step();
    check("t3_mtc0_issue", {131'd0, obs_iv}, 132'd1);
    rob_head = 4'd8;
    step();
    check("t3_held_iv", {131'd0, obs_iv}, 132'd0);
    check("t3_busy", {131'd0, obs_sb}, 132'd1);
    commit_valid = 1'b1; commit_rob_entry = 4'd8;
    step();
    check("t3_mismatch_commit_iv", {131'd0, obs_iv}, 132'd0);
    check("t3_mismatch_commit_busy", {131'd0, obs_sb}, 132'd1);
    commit_rob_entry = 4'd7;
    step();
    check("t3_commit_cycle_iv", {131'd0, obs_iv}, 132'd0);
    check("t3_commit_cycle_busy", {131'd0, obs_sb}, 132'd1);
    commit_valid = 1'b0;
    step();
    check("t3_mfc0_issue", {131'd0, obs_iv}, 132'd1);
    check("t3_busy_clear", {131'd0, obs_sb}, 132'd0);

    // Fill the queue, hold a fifth op, release by popping; pointers wrap.
    rob_head = 4'd0;
    for (int i = 1; i <= 4; i++) begin
      drive_enq(4'(i), 1'b0); exp_q.push_back(4'(i));
      step();
      check("t4_fill_ready", {131'd0, obs_er}, 132'd1);
    end
    drive_enq(4'd5, 1'b0);
    step();
    check("t4_full_not_ready", {131'd0, obs_er}, 132'd0);
    rob_head = 4'd1;
    step();
    check("t4_full_pop_not_ready", {131'd0, obs_er}, 132'd0);
    check("t4_pop_issue", {131'd0, obs_iv}, 132'd1);
    rob_head = 4'd2; exp_q.push_back(4'd5);
    step();
    check("t4_ready_after_pop", {131'd0, obs_er}, 132'd1);
    check("t4_issue_2", {131'd0, obs_iv}, 132'd1);
    enq_valid = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      rob_head = 4'(i);
      step();
      check("t4_drain_issue", {131'd0, obs_iv}, 132'd1);
    end

    // Flush while waiting on a serial op with three queued and an enqueue pending.
    rob_head = 4'd5;
    drive_enq(4'd6, 1'b1); exp_q.push_back(4'd6); step();
    drive_enq(4'd7, 1'b0); exp_q.push_back(4'd7); step();
    drive_enq(4'd8, 1'b0); exp_q.push_back(4'd8); step();
    drive_enq(4'd9, 1'b0); exp_q.push_back(4'd9); rob_head = 4'd6;
    step();
    check("t5_serial_issue", {131'd0, obs_iv}, 132'd1);
    exp_q.delete();
    flush = 1'b1; drive_enq(4'd10, 1'b0); rob_head = 4'd7;
    commit_valid = 1'b1; commit_rob_entry = 4'd6;
    step();
    check("t5_flush_no_issue", {131'd0, obs_iv}, 132'd0);
    flush = 1'b0; enq_valid = 1'b0; commit_valid = 1'b0;
    step();
    check("t5_after_flush_iv", {131'd0, obs_iv}, 132'd0);
    check("t5_after_flush_idle", {131'd0, obs_sb}, 132'd0);
    check("t5_after_flush_ready", {131'd0, obs_er}, 132'd1);
    rob_head = 4'd10;
    step();
    check("t5_nothing_pushed", {131'd0, obs_iv}, 132'd0);

    // ROB index wrap 15 -> 0.
    rob_head = 4'd14;
    drive_enq(4'd15, 1'b0); exp_q.push_back(4'd15); step();
    check("t6_wrap_hold_15", {131'd0, obs_iv}, 132'd0);
    drive_enq(4'd0, 1'b0); exp_q.push_back(4'd0); step();
    check("t6_wrap_hold_0", {131'd0, obs_iv}, 132'd0);
    enq_valid = 1'b0; rob_head = 4'd15;
    step();
    check("t6_issue_15", {131'd0, obs_iv}, 132'd1);
    rob_head = 4'd0;
    step();
    check("t6_issue_0", {131'd0, obs_iv}, 132'd1);

    // Empty queue, enqueue at ROB head: same cycle with bypass, else next cycle.
    rob_head = 4'd3;
    drive_enq(4'd3, 1'b0); exp_q.push_back(4'd3);
    step();
    check("t6_head_enq_same_cycle", {131'd0, obs_iv}, {131'd0, BYP});
    enq_valid = 1'b0;
    step();
    check("t6_head_enq_next_cycle", {131'd0, obs_iv}, {131'd0, ~BYP});
    step();

    check("scoreboard_empty", 132'(exp_q.size()), 132'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
